// File: rtl/lbist_pkg.sv
// Shared constants, types and helpers for the LBIST register/control block.
package lbist_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_CFG    = 1;
  localparam int unsigned ADDR_STATUS = 2;
  localparam int unsigned ADDR_TMO    = 3;
  localparam int unsigned ADDR_GOLD0  = 4;

  localparam int unsigned CTRL_RST    = 0;
  localparam int unsigned CTRL_START  = 1;
  localparam int unsigned CTRL_RSB    = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;
  localparam int unsigned CTRL_CH_EN  = 8;

  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned ST_DONE     = 1;
  localparam int unsigned ST_FAIL     = 2;
  localparam int unsigned ST_TMO      = 3;
  localparam int unsigned ST_CH_FAIL  = 8;
  localparam int unsigned ST_RAW_DONE = 31;

  typedef enum logic [1:0] {IDLE, RUN, CAP, CMP} lbist_state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } reg_req_t;

  // Captured signatures sit directly after the golden bank.
  function automatic int unsigned addr_cap0(input int unsigned num_ch);
    return ADDR_GOLD0 + num_ch;
  endfunction

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] wdata,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lbist_tmo_cnt.sv
// Run-supervision down-counter: loads the limit at start, expires on reaching 1.
module lbist_tmo_cnt #(
  parameter int unsigned TMO_W = 24
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMO_W-1:0] load_val,
  input  logic             en,
  output logic             expire_c
);

  logic [TMO_W-1:0] cnt;
  logic             active;

  // A zero load value leaves the counter parked, which disables the timeout.
  assign active   = en && (cnt != '0);
  assign expire_c = active && (cnt == TMO_W'(1));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (load)   cnt <= load_val;
    else if (active) cnt <= cnt - TMO_W'(1);
  end

endmodule

// File: rtl/lbist_reg_mc.sv
// LBIST register file and run sequencer: start/done handshake, signature
// capture/compare, timeout supervision and sticky status with interrupt.
module lbist_reg_mc
  import lbist_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned SIG_W   = 32,
  parameter int unsigned TMO_W   = 24,
  parameter logic [31:0] CFG_RST = 32'h4C66_8354
) (
  input  logic                    mclk,
  input  logic                    reset_n,
  input  logic                    reg_cs,
  input  logic                    reg_wr,
  input  logic [3:0]              reg_addr,
  input  logic [31:0]             reg_wdata,
  input  logic [3:0]              reg_be,
  output logic [31:0]             reg_rdata,
  output logic                    reg_ack,
  output logic                    cfg_lbist_rst,
  output logic                    cfg_lbist_start,
  output logic                    cfg_lbist_rsb,
  output logic [NUM_CH-1:0]       cfg_ch_en,
  output logic [15:0]             cfg_lbist_pat,
  output logic [15:0]             cfg_chain_depth,
  input  logic                    lbist_done,
  input  logic [NUM_CH*SIG_W-1:0] lbist_sig,
  output logic                    lbist_busy,
  output logic                    lbist_irq
);

  localparam int unsigned CAP0 = addr_cap0(NUM_CH);

  lbist_state_t state, state_nxt;
  reg_req_t     req;
  logic acc, wr_acc;
  logic ctrl_wr, cfg_wr, status_wr, tmo_wr;
  logic start_req, abort_req;
  logic clr_done, clr_fail, clr_tmo;
  logic do_start, do_cap, do_cmp, do_tmo, do_abort;
  logic done_q, done_rise, tmo_expire_c;

  logic              rst_q, rsb_q, irq_en_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic [31:0]       cfg_q;
  logic [TMO_W-1:0]  tmo_lim_q;
  logic [SIG_W-1:0]  gold_q [NUM_CH];
  logic [SIG_W-1:0]  cap_q  [NUM_CH];

  logic              busy_q, st_done_q, st_fail_q, st_tmo_q, irq_q;
  logic [NUM_CH-1:0] st_chf_q, chf_c;
  logic [31:0]       rd_c;

  assign req = '{wr: reg_wr, addr: reg_addr, wdata: reg_wdata, be: reg_be};

  // One access per idle-ack cycle; writes land on the edge that raises ack.
  assign acc       = reg_cs && !reg_ack;
  assign wr_acc    = acc && req.wr;
  assign ctrl_wr   = wr_acc && (req.addr == 4'(ADDR_CTRL));
  assign cfg_wr    = wr_acc && (req.addr == 4'(ADDR_CFG));
  assign status_wr = wr_acc && (req.addr == 4'(ADDR_STATUS));
  assign tmo_wr    = wr_acc && (req.addr == 4'(ADDR_TMO));

  assign start_req = ctrl_wr && req.be[0] && req.wdata[CTRL_START];
  assign abort_req = ctrl_wr && req.be[0] && req.wdata[CTRL_RST];
  assign clr_done  = status_wr && req.be[0] && req.wdata[ST_DONE];
  assign clr_fail  = status_wr && req.be[0] && req.wdata[ST_FAIL];
  assign clr_tmo   = status_wr && req.be[0] && req.wdata[ST_TMO];

  assign done_rise = lbist_done && !done_q;

  lbist_tmo_cnt #(.TMO_W(TMO_W)) u_tmo_cnt (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .load     (do_start),
    .load_val (tmo_lim_q),
    .en       (state == RUN),
    .expire_c (tmo_expire_c)
  );

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Sequencer: abort has priority over every run event.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_cap    = 1'b0;
    do_cmp    = 1'b0;
    do_tmo    = 1'b0;
    do_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && !rst_q && !abort_req) begin
          do_start  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_req) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else if (done_rise) begin
          state_nxt = CAP;
        end else if (tmo_expire_c) begin
          do_tmo    = 1'b1;
          state_nxt = IDLE;
        end
      end
      CAP: begin
        if (abort_req) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          do_cap    = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (abort_req) begin
          do_abort  = 1'b1;
        end else begin
          do_cmp    = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    chf_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      chf_c[i] = ch_en_q[i] && !rsb_q && (cap_q[i] != gold_q[i]);
    end
  end

  always_comb begin
    rd_c = '0;
    case (req.addr)
      4'(ADDR_CTRL): begin
        rd_c[CTRL_RST]              = rst_q;
        rd_c[CTRL_RSB]              = rsb_q;
        rd_c[CTRL_IRQ_EN]           = irq_en_q;
        rd_c[CTRL_CH_EN +: NUM_CH]  = ch_en_q;
      end
      4'(ADDR_CFG): rd_c = cfg_q;
      4'(ADDR_STATUS): begin
        rd_c[ST_BUSY]               = busy_q;
        rd_c[ST_DONE]               = st_done_q;
        rd_c[ST_FAIL]               = st_fail_q;
        rd_c[ST_TMO]                = st_tmo_q;
        rd_c[ST_CH_FAIL +: NUM_CH]  = st_chf_q;
        rd_c[ST_RAW_DONE]           = lbist_done;
      end
      4'(ADDR_TMO): rd_c[TMO_W-1:0] = tmo_lim_q;
      default: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (req.addr == 4'(ADDR_GOLD0 + i)) rd_c[SIG_W-1:0] = gold_q[i];
          if (req.addr == 4'(CAP0 + i))       rd_c[SIG_W-1:0] = cap_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      done_q    <= 1'b0;
    end else begin
      reg_ack   <= acc;
      reg_rdata <= (acc && !req.wr) ? rd_c : '0;
      done_q    <= lbist_done;
    end
  end

  // Software-owned configuration.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rst_q     <= 1'b0;
      rsb_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      ch_en_q   <= '1;
      cfg_q     <= CFG_RST;
      tmo_lim_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) gold_q[i] <= '0;
    end else begin
      if (ctrl_wr && req.be[0]) begin
        rst_q    <= req.wdata[CTRL_RST];
        rsb_q    <= req.wdata[CTRL_RSB];
        irq_en_q <= req.wdata[CTRL_IRQ_EN];
      end
      if (ctrl_wr && req.be[1]) ch_en_q <= req.wdata[CTRL_CH_EN +: NUM_CH];
      if (cfg_wr) cfg_q <= be_merge(cfg_q, req.wdata, req.be);
      if (tmo_wr) tmo_lim_q <= TMO_W'(be_merge(32'(tmo_lim_q), req.wdata, req.be));
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (wr_acc && (req.addr == 4'(ADDR_GOLD0 + i)))
          gold_q[i] <= SIG_W'(be_merge(32'(gold_q[i]), req.wdata, req.be));
      end
    end
  end

  // Run state and sticky status; hardware sets override same-cycle W1C.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_lbist_start <= 1'b0;
      busy_q          <= 1'b0;
      st_done_q       <= 1'b0;
      st_fail_q       <= 1'b0;
      st_tmo_q        <= 1'b0;
      st_chf_q        <= '0;
      irq_q           <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) cap_q[i] <= '0;
    end else begin
      cfg_lbist_start <= do_start;

      if (do_start)                          busy_q <= 1'b1;
      else if (do_abort || do_tmo || do_cmp) busy_q <= 1'b0;

      if (do_cap) begin
        for (int i = 0; i < int'(NUM_CH); i++) cap_q[i] <= lbist_sig[i*SIG_W +: SIG_W];
      end

      if (do_cmp)                    st_done_q <= 1'b1;
      else if (do_start || clr_done) st_done_q <= 1'b0;

      if (do_cmp) begin
        st_fail_q <= |chf_c;
        st_chf_q  <= chf_c;
      end else if (do_start || clr_fail) begin
        st_fail_q <= 1'b0;
        st_chf_q  <= '0;
      end

      if (do_tmo)                   st_tmo_q <= 1'b1;
      else if (do_start || clr_tmo) st_tmo_q <= 1'b0;

      irq_q <= irq_en_q && (st_done_q || st_tmo_q);
    end
  end

  assign cfg_lbist_rst   = rst_q;
  assign cfg_lbist_rsb   = rsb_q;
  assign cfg_ch_en       = ch_en_q;
  assign cfg_lbist_pat   = cfg_q[31:16];
  assign cfg_chain_depth = cfg_q[15:0];
  assign lbist_busy      = busy_q;
  assign lbist_irq       = irq_q;

endmodule
